// File: rtl/alu_seq_ctrl.sv
// Sequencer that feeds an external registered ALU from a small register file.
// Each command runs IDLE -> ISSUE -> CAPTURE, and the result is written back to register DST.
module alu_seq_ctrl #(
   parameter int ADDR_W = 3
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [3:0]        CMD_OP,
   input  logic [ADDR_W-1:0] CMD_SRC_A,
   input  logic [ADDR_W-1:0] CMD_SRC_B,
   input  logic [ADDR_W-1:0] CMD_DST,
   input  logic              WR_EN,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [15:0]       WR_DATA,
   output logic [15:0]       A,
   output logic [15:0]       B,
   output logic [3:0]        ALU_FUN,
   input  logic [15:0]       ALU_OUT,
   output logic              RES_VALID,
   output logic [15:0]       RES_DATA,
   output logic              RES_ERR,
   input  logic [ADDR_W-1:0] RD_ADDR,
   output logic [15:0]       RD_DATA
);

   localparam int         NUM_REGS = 1 << ADDR_W;
   localparam logic [3:0] OP_DIV   = 4'b0011;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      CAPTURE = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       rf [NUM_REGS];
   logic [ADDR_W-1:0] dst_q;
   logic [15:0]       opnd_a;
   logic [15:0]       opnd_b;
   logic              accept;
   logic              div_err;
   logic              cap_wr;

   assign accept = (state == IDLE) && CMD_VALID;

   // A host write in the accept cycle must be visible to the operand fetch.
   assign opnd_a = (WR_EN && (WR_ADDR == CMD_SRC_A)) ? WR_DATA : rf[CMD_SRC_A];
   assign opnd_b = (WR_EN && (WR_ADDR == CMD_SRC_B)) ? WR_DATA : rf[CMD_SRC_B];

   assign div_err = (ALU_FUN == OP_DIV) && (B == 16'h0000);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt = state;
      CMD_READY = 1'b0;
      RES_VALID = 1'b0;
      RES_DATA  = 16'h0000;
      RES_ERR   = 1'b0;
      cap_wr    = 1'b0;
      case (state)
         IDLE: begin
            CMD_READY = 1'b1;
            if (CMD_VALID) state_nxt = ISSUE;
         end
         ISSUE: state_nxt = CAPTURE;
         CAPTURE: begin
            RES_VALID = 1'b1;
            RES_ERR   = div_err;
            RES_DATA  = div_err ? 16'hFFFF : ALU_OUT;
            cap_wr    = !div_err;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= IDLE;
      else      state <= state_nxt;
   end

   // Operand and op registers stay stable from accept until the next accept.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         A       <= 16'h0000;
         B       <= 16'h0000;
         ALU_FUN <= 4'h0;
         dst_q   <= '0;
      end else if (accept) begin
         A       <= opnd_a;
         B       <= opnd_b;
         ALU_FUN <= CMD_OP;
         dst_q   <= CMD_DST;
      end
   end

   // NOTE: the register file is reset entry by entry because its reset contents are architecturally visible.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= 16'h0000;
      end else begin
         if (WR_EN)  rf[WR_ADDR] <= WR_DATA;
         // Later assignment wins, so the CAPTURE write overrides a colliding host write.
         if (cap_wr) rf[dst_q]   <= ALU_OUT;
      end
   end

   assign RD_DATA = rf[RD_ADDR];

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl: a table of single commands plus hand-written
// sequences for back-to-back commands, bypass, write collision and mid-command reset.
module tb_alu_seq_ctrl;

   localparam int ADDR_W = 3;

   logic              CLK;
   logic              RST;
   logic              CMD_VALID;
   logic              CMD_READY;
   logic [3:0]        CMD_OP;
   logic [ADDR_W-1:0] CMD_SRC_A;
   logic [ADDR_W-1:0] CMD_SRC_B;
   logic [ADDR_W-1:0] CMD_DST;
   logic              WR_EN;
   logic [ADDR_W-1:0] WR_ADDR;
   logic [15:0]       WR_DATA;
   logic [15:0]       A;
   logic [15:0]       B;
   logic [3:0]        ALU_FUN;
   logic [15:0]       ALU_OUT;
   logic              RES_VALID;
   logic [15:0]       RES_DATA;
   logic              RES_ERR;
   logic [ADDR_W-1:0] RD_ADDR;
   logic [15:0]       RD_DATA;

   int n_vec  = 0;
   int n_fail = 0;

   alu_seq_ctrl #(.ADDR_W(ADDR_W)) dut (
      .CLK(CLK), .RST(RST),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_OP(CMD_OP),
      .CMD_SRC_A(CMD_SRC_A), .CMD_SRC_B(CMD_SRC_B), .CMD_DST(CMD_DST),
      .WR_EN(WR_EN), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA),
      .A(A), .B(B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
      .RES_VALID(RES_VALID), .RES_DATA(RES_DATA), .RES_ERR(RES_ERR),
      .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // External registered ALU; divide by zero returns a junk value the DUT must override.
   initial ALU_OUT = 16'h0000;
   always @(posedge CLK) begin
      case (ALU_FUN)
         4'b0000: ALU_OUT <= A + B;
         4'b0001: ALU_OUT <= A - B;
         4'b0010: ALU_OUT <= A & B;
         4'b0011: ALU_OUT <= (B == 16'h0000) ? 16'h1234 : A / B;
         default: ALU_OUT <= 16'h0000;
      endcase
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // All tasks start and end just after a falling edge.
   task automatic host_wr(input logic [ADDR_W-1:0] addr, input logic [15:0] data);
      WR_EN   = 1'b1;
      WR_ADDR = addr;
      WR_DATA = data;
      @(negedge CLK);
      WR_EN   = 1'b0;
   endtask

   task automatic read_chk(input string name, input logic [ADDR_W-1:0] addr, input logic [15:0] exp);
      RD_ADDR = addr;
      #1;
      check(name, RD_DATA, exp);
   endtask

   typedef struct {
      logic [3:0]        op;
      logic [ADDR_W-1:0] sa;
      logic [ADDR_W-1:0] sb;
      logic [ADDR_W-1:0] dst;
      logic [15:0]       a_val;
      logic [15:0]       b_val;
      logic [15:0]       pre;
      logic [15:0]       exp_data;
      logic              exp_err;
      logic [15:0]       exp_post;
   } vec_t;

   vec_t vecs [10];

   initial begin
      int rv_cnt;

      //          op       sa  sb  dst a_val     b_val     pre       data      err   post
      vecs[0] = '{4'b0000, 3'd1, 3'd2, 3'd3, 16'h0005, 16'h0003, 16'h0000, 16'h0008, 1'b0, 16'h0008};
      vecs[1] = '{4'b0011, 3'd1, 3'd2, 3'd4, 16'h0007, 16'h0000, 16'h00AA, 16'hFFFF, 1'b1, 16'h00AA};
      vecs[2] = '{4'b0001, 3'd5, 3'd6, 3'd7, 16'h0010, 16'h0003, 16'h0000, 16'h000D, 1'b0, 16'h000D};
      vecs[3] = '{4'b0001, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0001, 16'h0000, 16'hFFFF, 1'b0, 16'hFFFF};
      vecs[4] = '{4'b0011, 3'd2, 3'd3, 3'd5, 16'h0064, 16'h0007, 16'h0000, 16'h000E, 1'b0, 16'h000E};
      vecs[5] = '{4'b1111, 3'd1, 3'd2, 3'd6, 16'h0001, 16'h0002, 16'h5555, 16'h0000, 1'b0, 16'h0000};
      vecs[6] = '{4'b0000, 3'd3, 3'd3, 3'd3, 16'h4000, 16'h4000, 16'h4000, 16'h8000, 1'b0, 16'h8000};
      vecs[7] = '{4'b0010, 3'd4, 3'd5, 3'd4, 16'hF0F0, 16'h3C3C, 16'hF0F0, 16'h3030, 1'b0, 16'h3030};
      vecs[8] = '{4'b0011, 3'd0, 3'd7, 3'd7, 16'h0009, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 16'h0000};
      vecs[9] = '{4'b0001, 3'd5, 3'd6, 3'd1, 16'h0042, 16'h0000, 16'h0000, 16'h0042, 1'b0, 16'h0042};

      RST = 1'b0; CMD_VALID = 1'b0; CMD_OP = 4'h0;
      CMD_SRC_A = '0; CMD_SRC_B = '0; CMD_DST = '0;
      WR_EN = 1'b0; WR_ADDR = '0; WR_DATA = 16'h0000; RD_ADDR = '0;

      // Reset state
      @(negedge CLK);
      @(negedge CLK);
      check("rst_ready", {15'd0, CMD_READY}, 16'h0001);
      check("rst_valid", {15'd0, RES_VALID}, 16'h0000);
      check("rst_err",   {15'd0, RES_ERR},   16'h0000);
      check("rst_data",  RES_DATA, 16'h0000);
      check("rst_a",     A, 16'h0000);
      check("rst_b",     B, 16'h0000);
      check("rst_fun",   {12'd0, ALU_FUN}, 16'h0000);
      read_chk("rst_rf5", 3'd5, 16'h0000);
      RST = 1'b1;
      @(negedge CLK);

      // Single commands from the table
      for (int v = 0; v < 10; v++) begin
         host_wr(vecs[v].dst, vecs[v].pre);
         host_wr(vecs[v].sa,  vecs[v].a_val);
         host_wr(vecs[v].sb,  vecs[v].b_val);
         check($sformatf("v%0d_ready", v), {15'd0, CMD_READY}, 16'h0001);
         CMD_VALID = 1'b1;
         CMD_OP    = vecs[v].op;
         CMD_SRC_A = vecs[v].sa;
         CMD_SRC_B = vecs[v].sb;
         CMD_DST   = vecs[v].dst;
         @(negedge CLK);
         CMD_VALID = 1'b0;
         check($sformatf("v%0d_a", v),     A, vecs[v].a_val);
         check($sformatf("v%0d_b", v),     B, vecs[v].b_val);
         check($sformatf("v%0d_fun", v),   {12'd0, ALU_FUN}, {12'd0, vecs[v].op});
         check($sformatf("v%0d_issue_valid", v), {15'd0, RES_VALID}, 16'h0000);
         check($sformatf("v%0d_issue_ready", v), {15'd0, CMD_READY}, 16'h0000);
         @(negedge CLK);
         check($sformatf("v%0d_valid", v), {15'd0, RES_VALID}, 16'h0001);
         check($sformatf("v%0d_data", v),  RES_DATA, vecs[v].exp_data);
         check($sformatf("v%0d_err", v),   {15'd0, RES_ERR}, {15'd0, vecs[v].exp_err});
         @(negedge CLK);
         check($sformatf("v%0d_valid_low", v), {15'd0, RES_VALID}, 16'h0000);
         check($sformatf("v%0d_err_low", v),   {15'd0, RES_ERR},   16'h0000);
         read_chk($sformatf("v%0d_post", v), vecs[v].dst, vecs[v].exp_post);
      end

      // CMD_VALID held high: ready every third cycle, one result per accept
      host_wr(3'd1, 16'd10);
      host_wr(3'd2, 16'd3);
      CMD_VALID = 1'b1; CMD_OP = 4'b0001;
      CMD_SRC_A = 3'd1; CMD_SRC_B = 3'd2; CMD_DST = 3'd0;
      rv_cnt = 0;
      for (int i = 0; i < 12; i++) begin
         check($sformatf("stream_ready_%0d", i), {15'd0, CMD_READY}, (i % 3 == 0) ? 16'h0001 : 16'h0000);
         check($sformatf("stream_valid_%0d", i), {15'd0, RES_VALID}, (i % 3 == 2) ? 16'h0001 : 16'h0000);
         if (RES_VALID) rv_cnt++;
         @(negedge CLK);
      end
      CMD_VALID = 1'b0;
      check("stream_result_count", rv_cnt[15:0], 16'd4);
      read_chk("stream_r0", 3'd0, 16'd7);

      // Same-cycle host write bypass, then host write colliding with CAPTURE
      WR_EN = 1'b1; WR_ADDR = 3'd1; WR_DATA = 16'd9;
      CMD_VALID = 1'b1; CMD_OP = 4'b0000;
      CMD_SRC_A = 3'd1; CMD_SRC_B = 3'd2; CMD_DST = 3'd3;
      @(negedge CLK);
      WR_EN = 1'b0; CMD_VALID = 1'b0;
      check("bypass_a", A, 16'd9);
      check("bypass_b", B, 16'd3);
      @(negedge CLK);
      check("bypass_data", RES_DATA, 16'd12);
      WR_EN = 1'b1; WR_ADDR = 3'd3; WR_DATA = 16'hBEEF;
      @(negedge CLK);
      WR_EN = 1'b0;
      read_chk("collide_r3", 3'd3, 16'd12);
      read_chk("bypass_r1",  3'd1, 16'd9);

      // Reset during ISSUE aborts the command
      CMD_VALID = 1'b1; CMD_OP = 4'b0000;
      CMD_SRC_A = 3'd1; CMD_SRC_B = 3'd2; CMD_DST = 3'd6;
      @(negedge CLK);
      CMD_VALID = 1'b0;
      RST = 1'b0;
      #1;
      check("abort_valid_now", {15'd0, RES_VALID}, 16'h0000);
      @(negedge CLK);
      check("abort_valid_next", {15'd0, RES_VALID}, 16'h0000);
      RST = 1'b1;
      @(negedge CLK);
      check("abort_ready", {15'd0, CMD_READY}, 16'h0001);
      check("abort_valid", {15'd0, RES_VALID}, 16'h0000);
      check("abort_a",     A, 16'h0000);
      for (int r = 0; r < 8; r++) read_chk($sformatf("abort_rf%0d", r), r[ADDR_W-1:0], 16'h0000);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
